// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcode constants, FSM state
// encoding, instruction field positions and a register-write decode helper.
// Optional feature macro: CPU_MUL_EN (enables opcode B = MUL).
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS_MSB  = 23;
    localparam int RS_LSB  = 20;
    localparam int RT_MSB  = 19;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // True for opcodes that write a result into rd during WB.
    function automatic logic op_writes_rd(input logic [3:0] op);
        logic w;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LD: w = 1'b1;
`ifdef CPU_MUL_EN
            OP_MUL: w = 1'b1;
`endif
            default: w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 16 x DATA_W register file: two asynchronous read ports, one synchronous
// write port. r0 always reads as zero and ignores writes.
module cpu_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ra_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [3:0]        rb_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              we_i,
    input  logic [3:0]        wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] regs_q [0:15];

    // Register storage; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 1; i < 16; i++) begin
                if (we_i && (wa_i == 4'(i))) begin
                    regs_q[i] <= wd_i;
                end
            end
        end
    end

    // Asynchronous read ports with r0 forced to zero.
    always_comb begin
        if (ra_i == 4'd0) begin
            ra_data_o = {DATA_W{1'b0}};
        end else begin
            ra_data_o = regs_q[ra_i];
        end
        if (rb_i == 4'd0) begin
            rb_data_o = {DATA_W{1'b0}};
        end else begin
            rb_data_o = regs_q[rb_i];
        end
    end

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle CPU: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with a terminal HALT.
// Memory interfaces use req/ack handshakes; requests are decoded from the
// state register so they are stable for the whole FETCH/MEM phase.
// Optional feature macro: CPU_MUL_EN (opcode B computes rd = rs*rt).
// DATA_W must be at least 16 so the immediate fits the datapath.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              halted,
    output logic              retire,
    output logic [ADDR_W-1:0] pc_o
);

    localparam logic [ADDR_W-1:0] RESET_PC_L = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] npc_q, npc_d;

    logic [3:0]        op_s, rd_s, rs_s, rt_s;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] rf_a_s, rf_b_s;
    logic [DATA_W-1:0] alu_s;
    logic [ADDR_W-1:0] maddr_s, pc_inc_s, npc_s;
    logic              rf_we_s;
    logic [DATA_W-1:0] rf_wd_s;

    assign op_s  = ir_q[OPC_MSB:OPC_LSB];
    assign rd_s  = ir_q[RD_MSB:RD_LSB];
    assign rs_s  = ir_q[RS_MSB:RS_LSB];
    assign rt_s  = ir_q[RT_MSB:RT_LSB];
    assign imm_s = DATA_W'($signed(ir_q[IMM_MSB:IMM_LSB]));

    assign rf_we_s = (state_q == WB) && op_writes_rd(op_s);
    assign rf_wd_s = (op_s == OP_LD) ? mdr_q : alu_q;

    cpu_regfile #(
        .DATA_W(DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .ra_i      (rs_s),
        .ra_data_o (rf_a_s),
        .rb_i      (rt_s),
        .rb_data_o (rf_b_s),
        .we_i      (rf_we_s),
        .wa_i      (rd_s),
        .wd_i      (rf_wd_s)
    );

    // ALU result for the current instruction, using operands latched in DECODE.
    always_comb begin
        alu_s = {DATA_W{1'b0}};
        case (op_s)
            OP_ADD:  alu_s = a_q + b_q;
            OP_SUB:  alu_s = a_q - b_q;
            OP_AND:  alu_s = a_q & b_q;
            OP_OR:   alu_s = a_q | b_q;
            OP_XOR:  alu_s = a_q ^ b_q;
            OP_ADDI: alu_s = a_q + imm_s;
`ifdef CPU_MUL_EN
            OP_MUL:  alu_s = a_q * b_q;
`endif
            default: alu_s = {DATA_W{1'b0}};
        endcase
    end

    // Data address and next PC; both wrap naturally at ADDR_W bits.
    always_comb begin
        maddr_s  = a_q[ADDR_W-1:0] + imm_s[ADDR_W-1:0];
        pc_inc_s = pc_q + PC_ONE;
        if (op_s == OP_JMP) begin
            npc_s = imm_s[ADDR_W-1:0];
        end else if ((op_s == OP_BEQ) && (a_q == b_q)) begin
            npc_s = pc_inc_s + imm_s[ADDR_W-1:0];
        end else begin
            npc_s = pc_inc_s;
        end
    end

    // FSM next-state and datapath register updates; acks only matter in FETCH/MEM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        addr_d  = addr_q;
        npc_d   = npc_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                a_d     = rf_a_s;
                b_d     = rf_b_s;
                state_d = EXEC;
            end
            EXEC: begin
                alu_d  = alu_s;
                addr_d = maddr_s;
                npc_d  = npc_s;
                if ((op_s == OP_LD) || (op_s == OP_ST)) begin
                    state_d = MEM;
                end else if (op_s == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    mdr_d   = dmem_rdata;
                    state_d = WB;
                end else begin
                    state_d = MEM;
                end
            end
            WB: begin
                pc_d    = npc_q;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC_L;
            ir_q    <= 32'h0000_0000;
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
            alu_q   <= {DATA_W{1'b0}};
            mdr_q   <= {DATA_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            npc_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            npc_q   <= npc_d;
        end
    end

    // The state register resets to FETCH, so the fetch request is gated with
    // rst to keep it low during reset and to drop it without waiting for a clock.
    assign imem_req   = (state_q == FETCH) & rst;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == MEM);
    assign dmem_we    = (state_q == MEM) && (op_s == OP_ST);
    assign dmem_addr  = addr_q;
    assign dmem_wdata = b_q;
    assign halted     = (state_q == HALT);
    assign retire     = (state_q == WB);
    assign pc_o       = pc_q;

endmodule
